// File: rtl/addsub_chunked_if.sv
// Handshake and operand/result bundle for the chunked adder-subtractor.
interface addsub_chunked_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             sat;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] Sum;
    logic             Ovfl;
    logic             Cout;

    modport master (
        output in_valid, A, B, sub, sat, flush,
        input  in_ready, out_valid, Sum, Ovfl, Cout
    );

    modport slave (
        input  in_valid, A, B, sub, sat, flush,
        output in_ready, out_valid, Sum, Ovfl, Cout
    );
endinterface

// File: rtl/addsub_chunked.sv
// Multi-cycle signed/unsigned adder-subtractor: CHUNK bits per clock with a
// registered inter-slice carry, signed overflow flag and optional saturation.
module addsub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    addsub_chunked_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg, b_reg, work;
    logic             sat_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             ovfl_reg, cout_reg;

    logic             in_ready, accept, last;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] raw;
    logic             ovfl_c;
    logic [WIDTH-1:0] sat_val;

    // Handshake decode and next-state selection; flush overrides everything
    always_comb begin
        state_nx = state;
        in_ready = (state == IDLE) || (state == DONE);
        accept   = bus.in_valid && in_ready && !bus.flush;
        last     = (cnt == CW'(NCHUNK - 1));
        if (bus.flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = accept ? RUN : IDLE;
                RUN:     state_nx = last ? DONE : RUN;
                DONE:    state_nx = accept ? RUN : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Current slice add, working result with this slice merged, and overflow/saturation
    always_comb begin
        slice_sum = {1'b0, a_reg[cnt*CHUNK +: CHUNK]}
                  + {1'b0, b_reg[cnt*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        raw = work;
        raw[cnt*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        ovfl_c  = (a_reg[MSB] == b_reg[MSB]) && (raw[MSB] != a_reg[MSB]);
        sat_val = a_reg[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand capture, per-slice accumulation and output load on the final slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sat_reg  <= 1'b0;
            work     <= '0;
            sum_reg  <= '0;
            ovfl_reg <= 1'b0;
            cout_reg <= 1'b0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            a_reg   <= bus.A;
            b_reg   <= bus.B ^ {WIDTH{bus.sub}};
            sat_reg <= bus.sat;
            carry   <= bus.sub;
            cnt     <= '0;
            work    <= '0;
        end else if (state == RUN) begin
            work  <= raw;
            carry <= slice_sum[CHUNK];
            if (last) begin
                cnt      <= '0;
                sum_reg  <= (sat_reg && ovfl_c) ? sat_val : raw;
                ovfl_reg <= ovfl_c;
                cout_reg <= slice_sum[CHUNK];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.Sum       = sum_reg;
    assign bus.Ovfl      = ovfl_reg;
    assign bus.Cout      = cout_reg;
endmodule
